// File: rtl/slc3_ctrl_fsm_if.sv
// Control bundle between the SLC-3 control FSM (master) and the datapath (slave).
// Status inputs flow datapath -> FSM; load enables, gates, selects and strobes flow FSM -> datapath.
interface slc3_ctrl_fsm_if;
   logic        run_i;
   logic        continue_i;
   logic [15:0] ir;
   logic        n;
   logic        z;
   logic        p;

   logic        ld_mar;
   logic        ld_mdr;
   logic        ld_ir;
   logic        ld_pc;
   logic        ld_cc;
   logic        ld_reg;
   logic        ld_led;
   logic        gate_pc;
   logic        gate_mdr;
   logic        gate_alu;
   logic        gate_marmux;
   logic [1:0]  pcmux;
   logic [1:0]  addr2mux;
   logic        addr1mux;
   logic        drmux;
   logic        sr1mux;
   logic        sr2mux;
   logic [1:0]  aluk;
   logic        mem_mem_ena;
   logic        mem_wr_ena;

   modport master (
      input  run_i, continue_i, ir, n, z, p,
      output ld_mar, ld_mdr, ld_ir, ld_pc, ld_cc, ld_reg, ld_led,
             gate_pc, gate_mdr, gate_alu, gate_marmux,
             pcmux, addr2mux, addr1mux, drmux, sr1mux, sr2mux, aluk,
             mem_mem_ena, mem_wr_ena
   );

   modport slave (
      output run_i, continue_i, ir, n, z, p,
      input  ld_mar, ld_mdr, ld_ir, ld_pc, ld_cc, ld_reg, ld_led,
             gate_pc, gate_mdr, gate_alu, gate_marmux,
             pcmux, addr2mux, addr1mux, drmux, sr1mux, sr2mux, aluk,
             mem_mem_ena, mem_wr_ena
   );
endinterface

// File: rtl/slc3_ctrl_fsm.sv
// SLC-3 Moore control FSM: fetch / decode / execute sequencing with a latched BEN
// and memory accesses stretched over MEM_WAIT extra cycles.
module slc3_ctrl_fsm #(
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic          clk,
   input  logic          reset,
   slc3_ctrl_fsm_if.master bus
);

   localparam logic [3:0] OP_BR    = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_JSR   = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_LDR   = 4'b0110;
   localparam logic [3:0] OP_STR   = 4'b0111;
   localparam logic [3:0] OP_NOT   = 4'b1001;
   localparam logic [3:0] OP_JMP   = 4'b1100;
   localparam logic [3:0] OP_PAUSE = 4'b1101;

   localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

   typedef enum logic [4:0] {
      S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
      S_ADD, S_AND, S_NOT, S_BEN_CHK, S_BR_TAKE, S_JMP,
      S_JSR1, S_JSR2, S_LDR1, S_LDR2, S_LDR3,
      S_STR1, S_STR2, S_STR3,
      S_PAUSE1, S_PAUSE_WAIT, S_PAUSE2
   } state_e;

   state_e     state;
   state_e     state_nxt;
   logic [2:0] wait_cnt;
   logic [2:0] wait_cnt_nxt;
   logic       ben;
   logic       ben_nxt;
   logic       mem_done;

   assign mem_done = (wait_cnt == WAIT_LAST);

   // NOTE: sequential state uses <= so every flop samples pre-edge values; comb blocks use =.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_HALTED;
         wait_cnt <= '0;
         ben      <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         ben      <= ben_nxt;
      end
   end

   // The wait counter sits at 0 outside memory states, so entering one always starts a fresh count.
   always_comb begin
      // NOTE: defaults before the case keep every path assigned, so no latches are inferred.
      state_nxt    = state;
      wait_cnt_nxt = '0;
      ben_nxt      = ben;
      case (state)
         S_HALTED:  if (bus.run_i) state_nxt = S_FETCH1;
         S_FETCH1:  state_nxt = S_FETCH2;
         S_FETCH2: begin
            if (mem_done) state_nxt = S_FETCH3;
            else          wait_cnt_nxt = wait_cnt + 3'd1;
         end
         S_FETCH3:  state_nxt = S_DECODE;
         S_DECODE: begin
            ben_nxt = |(bus.ir[11:9] & {bus.n, bus.z, bus.p});
            case (bus.ir[15:12])
               OP_ADD:   state_nxt = S_ADD;
               OP_AND:   state_nxt = S_AND;
               OP_NOT:   state_nxt = S_NOT;
               OP_BR:    state_nxt = S_BEN_CHK;
               OP_JMP:   state_nxt = S_JMP;
               OP_JSR:   state_nxt = S_JSR1;
               OP_LDR:   state_nxt = S_LDR1;
               OP_STR:   state_nxt = S_STR1;
               OP_PAUSE: state_nxt = S_PAUSE1;
               default:  state_nxt = S_FETCH1;
            endcase
         end
         S_BEN_CHK: state_nxt = ben ? S_BR_TAKE : S_FETCH1;
         S_JSR1:    state_nxt = S_JSR2;
         S_LDR1:    state_nxt = S_LDR2;
         S_LDR2: begin
            if (mem_done) state_nxt = S_LDR3;
            else          wait_cnt_nxt = wait_cnt + 3'd1;
         end
         S_STR1:    state_nxt = S_STR2;
         S_STR2:    state_nxt = S_STR3;
         S_STR3: begin
            if (mem_done) state_nxt = S_FETCH1;
            else          wait_cnt_nxt = wait_cnt + 3'd1;
         end
         S_PAUSE1:     state_nxt = bus.continue_i ? S_PAUSE2 : S_PAUSE_WAIT;
         S_PAUSE_WAIT: if (bus.continue_i)  state_nxt = S_PAUSE2;
         S_PAUSE2:     if (!bus.continue_i) state_nxt = S_FETCH1;
         S_ADD, S_AND, S_NOT, S_BR_TAKE, S_JMP, S_JSR2, S_LDR3:
            state_nxt = S_FETCH1;
         default:   state_nxt = S_HALTED;
      endcase
   end

   always_comb begin
      bus.ld_mar      = 1'b0;
      bus.ld_mdr      = 1'b0;
      bus.ld_ir       = 1'b0;
      bus.ld_pc       = 1'b0;
      bus.ld_cc       = 1'b0;
      bus.ld_reg      = 1'b0;
      bus.ld_led      = 1'b0;
      bus.gate_pc     = 1'b0;
      bus.gate_mdr    = 1'b0;
      bus.gate_alu    = 1'b0;
      bus.gate_marmux = 1'b0;
      bus.pcmux       = 2'b00;
      bus.addr2mux    = 2'b00;
      bus.addr1mux    = 1'b0;
      bus.drmux       = 1'b0;
      bus.sr1mux      = 1'b0;
      bus.sr2mux      = 1'b0;
      bus.aluk        = 2'b00;
      bus.mem_mem_ena = 1'b0;
      bus.mem_wr_ena  = 1'b0;
      case (state)
         S_FETCH1: begin
            bus.gate_pc = 1'b1;
            bus.ld_mar  = 1'b1;
            bus.ld_pc   = 1'b1;
         end
         S_FETCH2, S_LDR2: begin
            bus.mem_mem_ena = 1'b1;
            bus.ld_mdr      = mem_done;
         end
         S_FETCH3: begin
            bus.gate_mdr = 1'b1;
            bus.ld_ir    = 1'b1;
         end
         S_ADD, S_AND, S_NOT: begin
            bus.gate_alu = 1'b1;
            bus.ld_reg   = 1'b1;
            bus.ld_cc    = 1'b1;
            bus.sr1mux   = 1'b1;
            bus.sr2mux   = bus.ir[5];
            bus.aluk     = (state == S_AND) ? 2'b01 : (state == S_NOT) ? 2'b10 : 2'b00;
         end
         S_BR_TAKE: begin
            bus.ld_pc    = 1'b1;
            bus.pcmux    = 2'b10;
            bus.addr2mux = 2'b10;
         end
         S_JMP: begin
            bus.ld_pc    = 1'b1;
            bus.pcmux    = 2'b10;
            bus.addr1mux = 1'b1;
            bus.sr1mux   = 1'b1;
         end
         S_JSR1: begin
            bus.gate_pc = 1'b1;
            bus.ld_reg  = 1'b1;
            bus.drmux   = 1'b1;
         end
         S_JSR2: begin
            bus.ld_pc    = 1'b1;
            bus.pcmux    = 2'b10;
            bus.addr2mux = 2'b11;
         end
         S_LDR1, S_STR1: begin
            bus.gate_marmux = 1'b1;
            bus.ld_mar      = 1'b1;
            bus.addr1mux    = 1'b1;
            bus.addr2mux    = 2'b01;
            bus.sr1mux      = 1'b1;
         end
         S_LDR3: begin
            bus.gate_mdr = 1'b1;
            bus.ld_reg   = 1'b1;
            bus.ld_cc    = 1'b1;
         end
         // Source register is ir[11:9] here and is passed through the ALU unchanged.
         S_STR2: begin
            bus.aluk     = 2'b11;
            bus.gate_alu = 1'b1;
            bus.ld_mdr   = 1'b1;
         end
         S_STR3: begin
            bus.mem_mem_ena = 1'b1;
            bus.mem_wr_ena  = 1'b1;
         end
         S_PAUSE1: bus.ld_led = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_slc3_ctrl_fsm.sv
// Self-checking bench for slc3_ctrl_fsm: directed vector table, hand-written corner sequences,
// and random instruction streams against an instruction-level timeline model.
module tb_slc3_ctrl_fsm;

  localparam int MW0 = 1;
  localparam int MW1 = 2;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_cc, ld_reg, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, addr2mux;
    logic       addr1mux, drmux, sr1mux, sr2mux;
    logic [1:0] aluk;
    logic       mem_mem_ena, mem_wr_ena;
  } ctrl_t;

  typedef struct {
    ctrl_t      exp;
    logic       cont;
    logic [2:0] nzp;
  } cyc_t;

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  nzp;
    int          n_exec;
    ctrl_t       first;
    ctrl_t       last;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        run_v  [2];
  logic        cont_v [2];
  logic [15:0] ir_v   [2];
  logic [2:0]  nzp_v  [2];
  ctrl_t       obs0, obs1;

  int n_tests = 0;
  int n_fail  = 0;

  cyc_t  plan[$];
  ctrl_t cap[$];

  logic [3:0] ops [12] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hC, 4'hD, 4'h2, 4'h8, 4'hF};

  slc3_ctrl_fsm_if if0();
  slc3_ctrl_fsm_if if1();

  slc3_ctrl_fsm #(.MEM_WAIT(MW0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  slc3_ctrl_fsm #(.MEM_WAIT(MW1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  assign if0.run_i = run_v[0];
  assign if0.continue_i = cont_v[0];
  assign if0.ir = ir_v[0];
  assign {if0.n, if0.z, if0.p} = nzp_v[0];
  assign if1.run_i = run_v[1];
  assign if1.continue_i = cont_v[1];
  assign if1.ir = ir_v[1];
  assign {if1.n, if1.z, if1.p} = nzp_v[1];

  assign obs0 = {if0.ld_mar, if0.ld_mdr, if0.ld_ir, if0.ld_pc, if0.ld_cc, if0.ld_reg, if0.ld_led,
                 if0.gate_pc, if0.gate_mdr, if0.gate_alu, if0.gate_marmux,
                 if0.pcmux, if0.addr2mux, if0.addr1mux, if0.drmux, if0.sr1mux, if0.sr2mux,
                 if0.aluk, if0.mem_mem_ena, if0.mem_wr_ena};
  assign obs1 = {if1.ld_mar, if1.ld_mdr, if1.ld_ir, if1.ld_pc, if1.ld_cc, if1.ld_reg, if1.ld_led,
                 if1.gate_pc, if1.gate_mdr, if1.gate_alu, if1.gate_marmux,
                 if1.pcmux, if1.addr2mux, if1.addr1mux, if1.drmux, if1.sr1mux, if1.sr2mux,
                 if1.aluk, if1.mem_mem_ena, if1.mem_wr_ena};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input ctrl_t c, input logic cont, input logic [2:0] z);
    cyc_t e;
    e.exp  = c;
    e.cont = cont;
    e.nzp  = z;
    plan.push_back(e);
  endtask

  // Instruction-level reference: the expected control word for every cycle from FETCH1
  // until the cycle before the next FETCH1, plus the continue_i/nzp to drive in that cycle.
  task automatic build_plan(input int mw, input logic [15:0] ir, input logic [2:0] nzp,
                            input int pa, input int pb);
    ctrl_t      c;
    logic       ben;
    logic [2:0] late;
    plan.delete();
    late = ~nzp;
    ben  = |(ir[11:9] & nzp);
    c = '0; c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1;
    push(c, 1'b0, nzp);
    for (int i = 0; i <= mw; i++) begin
      c = '0; c.mem_mem_ena = 1'b1; c.ld_mdr = (i == mw);
      push(c, 1'b0, nzp);
    end
    c = '0; c.gate_mdr = 1'b1; c.ld_ir = 1'b1;
    push(c, 1'b0, nzp);
    push('0, 1'b0, nzp);
    case (ir[15:12])
      4'h1, 4'h5, 4'h9: begin
        c = '0; c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; c.sr1mux = 1'b1;
        c.sr2mux = ir[5];
        c.aluk = (ir[15:12] == 4'h1) ? 2'b00 : (ir[15:12] == 4'h5) ? 2'b01 : 2'b10;
        push(c, 1'b0, late);
      end
      4'h0: begin
        push('0, 1'b0, late);
        if (ben) begin
          c = '0; c.ld_pc = 1'b1; c.pcmux = 2'b10; c.addr2mux = 2'b10;
          push(c, 1'b0, late);
        end
      end
      4'hC: begin
        c = '0; c.ld_pc = 1'b1; c.pcmux = 2'b10; c.addr1mux = 1'b1; c.sr1mux = 1'b1;
        push(c, 1'b0, late);
      end
      4'h4: begin
        c = '0; c.gate_pc = 1'b1; c.ld_reg = 1'b1; c.drmux = 1'b1;
        push(c, 1'b0, late);
        c = '0; c.ld_pc = 1'b1; c.pcmux = 2'b10; c.addr2mux = 2'b11;
        push(c, 1'b0, late);
      end
      4'h6, 4'h7: begin
        c = '0; c.gate_marmux = 1'b1; c.ld_mar = 1'b1; c.addr1mux = 1'b1;
        c.addr2mux = 2'b01; c.sr1mux = 1'b1;
        push(c, 1'b0, late);
        if (ir[15:12] == 4'h6) begin
          for (int i = 0; i <= mw; i++) begin
            c = '0; c.mem_mem_ena = 1'b1; c.ld_mdr = (i == mw);
            push(c, 1'b0, late);
          end
          c = '0; c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
          push(c, 1'b0, late);
        end else begin
          c = '0; c.aluk = 2'b11; c.gate_alu = 1'b1; c.ld_mdr = 1'b1;
          push(c, 1'b0, late);
          for (int i = 0; i <= mw; i++) begin
            c = '0; c.mem_mem_ena = 1'b1; c.mem_wr_ena = 1'b1;
            push(c, 1'b0, late);
          end
        end
      end
      4'hD: begin
        c = '0; c.ld_led = 1'b1;
        push(c, 1'b0, late);
        for (int j = 1; j <= pa + pb + 1; j++)
          push('0, (j >= pa + 1) && (j <= pa + pb), late);
      end
      default: ;
    endcase
  endtask

  // Starts with the DUT in FETCH1 (at posedge+1) and ends at posedge+1 of the following FETCH1.
  task automatic run_instr(input int sel, input logic [15:0] ir, input logic [2:0] nzp,
                           input int pa, input int pb, input int max_cyc);
    ctrl_t got;
    int    lim;
    build_plan((sel != 0) ? MW1 : MW0, ir, nzp, pa, pb);
    cap.delete();
    lim = (max_cyc < 0) ? plan.size() : max_cyc;
    for (int k = 0; k < lim; k++) begin
      ir_v[sel]   = ir;
      nzp_v[sel]  = plan[k].nzp;
      cont_v[sel] = plan[k].cont;
      run_v[sel]  = 1'($urandom);
      #1;
      got = (sel != 0) ? obs1 : obs0;
      cap.push_back(got);
      check($sformatf("dut%0d ir=%h cyc%0d", sel, ir, k), 32'(got), 32'(plan[k].exp));
      check($sformatf("dut%0d gate_onehot cyc%0d", sel, k),
            32'($countones({got.gate_pc, got.gate_mdr, got.gate_alu, got.gate_marmux}) <= 1), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input int sel);
    run_v[sel] = 1'b1;
    #1;
    check($sformatf("dut%0d halted_out", sel), 32'((sel != 0) ? obs1 : obs0), 32'd0);
    @(posedge clk);
    #1;
    run_v[sel] = 1'b0;
  endtask

  initial begin
    vec_t        tbl [10];
    logic [15:0] rir;
    int          cnt_a, cnt_b, cnt_c;

    tbl[0] = '{16'h1283, 3'b000, 1,
               '{gate_alu: 1'b1, ld_reg: 1'b1, ld_cc: 1'b1, sr1mux: 1'b1, default: '0},
               '{gate_alu: 1'b1, ld_reg: 1'b1, ld_cc: 1'b1, sr1mux: 1'b1, default: '0}};
    tbl[1] = '{16'h5060, 3'b111, 1,
               '{gate_alu: 1'b1, ld_reg: 1'b1, ld_cc: 1'b1, sr1mux: 1'b1, sr2mux: 1'b1, aluk: 2'b01, default: '0},
               '{gate_alu: 1'b1, ld_reg: 1'b1, ld_cc: 1'b1, sr1mux: 1'b1, sr2mux: 1'b1, aluk: 2'b01, default: '0}};
    tbl[2] = '{16'h907F, 3'b100, 1,
               '{gate_alu: 1'b1, ld_reg: 1'b1, ld_cc: 1'b1, sr1mux: 1'b1, sr2mux: 1'b1, aluk: 2'b10, default: '0},
               '{gate_alu: 1'b1, ld_reg: 1'b1, ld_cc: 1'b1, sr1mux: 1'b1, sr2mux: 1'b1, aluk: 2'b10, default: '0}};
    tbl[3] = '{16'h0A05, 3'b010, 1, ctrl_t'('0), ctrl_t'('0)};
    tbl[4] = '{16'h0A05, 3'b001, 2, ctrl_t'('0),
               '{ld_pc: 1'b1, pcmux: 2'b10, addr2mux: 2'b10, default: '0}};
    tbl[5] = '{16'hC1C0, 3'b000, 1,
               '{ld_pc: 1'b1, pcmux: 2'b10, addr1mux: 1'b1, sr1mux: 1'b1, default: '0},
               '{ld_pc: 1'b1, pcmux: 2'b10, addr1mux: 1'b1, sr1mux: 1'b1, default: '0}};
    tbl[6] = '{16'h4800, 3'b000, 2,
               '{gate_pc: 1'b1, ld_reg: 1'b1, drmux: 1'b1, default: '0},
               '{ld_pc: 1'b1, pcmux: 2'b10, addr2mux: 2'b11, default: '0}};
    tbl[7] = '{16'h6281, 3'b000, 4,
               '{gate_marmux: 1'b1, ld_mar: 1'b1, addr1mux: 1'b1, addr2mux: 2'b01, sr1mux: 1'b1, default: '0},
               '{gate_mdr: 1'b1, ld_reg: 1'b1, ld_cc: 1'b1, default: '0}};
    tbl[8] = '{16'h7281, 3'b000, 4,
               '{gate_marmux: 1'b1, ld_mar: 1'b1, addr1mux: 1'b1, addr2mux: 2'b01, sr1mux: 1'b1, default: '0},
               '{mem_mem_ena: 1'b1, mem_wr_ena: 1'b1, default: '0}};
    tbl[9] = '{16'h8000, 3'b000, 0, ctrl_t'('0), ctrl_t'('0)};

    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      run_v[s] = 1'b0; cont_v[s] = 1'b0; ir_v[s] = '0; nzp_v[s] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset_out dut0", 32'(obs0), 32'd0);
    check("reset_out dut1", 32'(obs1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("halted_idle dut0", 32'(obs0), 32'd0);
    end

    // Directed vectors on the MEM_WAIT = 1 instance; fetch + decode take 5 cycles there.
    start(0);
    foreach (tbl[i]) begin
      run_instr(0, tbl[i].ir, tbl[i].nzp, 0, 1, -1);
      check($sformatf("vec%0d length", i), 32'(cap.size()), 32'(5 + tbl[i].n_exec));
      if (tbl[i].n_exec > 0 && cap.size() >= 6) begin
        check($sformatf("vec%0d first_exec", i), 32'(cap[5]), 32'(tbl[i].first));
        check($sformatf("vec%0d last_exec", i), 32'(cap[cap.size() - 1]), 32'(tbl[i].last));
      end
      if (i == 0 && cap.size() >= 5) begin
        check("fetch c2 ld_mdr", 32'(cap[1].ld_mdr), 32'd0);
        check("fetch c2 mem", 32'(cap[1].mem_mem_ena), 32'd1);
        check("fetch c3 ld_mdr", 32'(cap[2].ld_mdr), 32'd1);
        check("fetch c4 ld_ir", 32'(cap[3].ld_ir), 32'd1);
      end
    end

    // PAUSE: led pulse once, hold 3 cycles with continue low, 3 high, then release.
    run_instr(0, 16'hD0FF, 3'b000, 2, 3, -1);
    cnt_a = 0;
    foreach (cap[k]) if (cap[k].ld_led) cnt_a++;
    check("pause ld_led cycles", 32'(cnt_a), 32'd1);
    check("pause length", 32'(cap.size()), 32'd12);
    run_instr(0, 16'h1283, 3'b000, 0, 1, -1);

    for (int t = 0; t < 60; t++) begin
      rir = {ops[$urandom_range(0, 11)], 12'($urandom)};
      run_instr(0, rir, 3'($urandom), $urandom_range(0, 3), $urandom_range(1, 3), -1);
    end

    // Asynchronous reset in the middle of LDR2's memory access.
    run_instr(0, 16'h6281, 3'b000, 0, 1, 6);
    #1;
    check("ldr2 mem before reset", 32'(obs0.mem_mem_ena), 32'd1);
    #1;
    reset = 1'b1;
    run_v[0] = 1'b0;
    #1;
    check("reset mid ldr2 drop", 32'(obs0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("post_reset idle", 32'(obs0), 32'd0);
    end
    start(0);
    run_instr(0, 16'h1283, 3'b000, 0, 1, -1);

    // STR on the MEM_WAIT = 2 instance.
    start(1);
    run_instr(1, 16'h7281, 3'b000, 0, 1, -1);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    foreach (cap[k]) begin
      if (cap[k].mem_wr_ena && cap[k].mem_mem_ena) cnt_a++;
      if (cap[k].mem_wr_ena && !cap[k].mem_mem_ena) cnt_b++;
      if (cap[k].ld_mdr && cap[k].aluk == 2'b11) cnt_c++;
    end
    check("str write cycles", 32'(cnt_a), 32'd3);
    check("str wr without mem", 32'(cnt_b), 32'd0);
    check("str ld_mdr passa", 32'(cnt_c), 32'd1);
    check("str length", 32'(cap.size()), 32'd11);

    for (int t = 0; t < 60; t++) begin
      rir = {ops[$urandom_range(0, 11)], 12'($urandom)};
      run_instr(1, rir, 3'($urandom), $urandom_range(0, 3), $urandom_range(1, 3), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
